psm_pulse_gen: RTL and testbench

Upstream stage of the PSM dead-time/limiter block. Generates the raw single-ended PSM command (oPSM), a 50 % duty square wave with a programmable period in clk cycles. Pulse-density control uses a first-order sigma-delta accumulator that decides, at each period boundary, whether the period fires or is skipped. oPSM feeds the dead-time block's iPSM input directly; the same iPERIOD value drives that block's iFREQUENCY.

---
 rtl/psm_pulse_gen.sv | 125 ++++++++++++
 tb/tb_psm_pulse_gen.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/psm_pulse_gen.sv
// PSM carrier generator: 50 % square wave with sigma-delta period skipping.
// Optional SOFT_START_EN ramps the effective density up from 0 after each start.
module psm_pulse_gen #(
    parameter int PERIOD_W   = 16,
    parameter int DENS_W     = 8,
    parameter int MIN_PERIOD = 4,
    parameter int RAMP_DIV   = 16
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                iEN,
    input  logic [PERIOD_W-1:0] iPERIOD,
    input  logic [DENS_W-1:0]   iDENSITY,
    output logic                oPSM,
    output logic                oSYNC,
    output logic                oFIRE,
    output logic                oBUSY
);

    if (MIN_PERIOD < 4 || (MIN_PERIOD % 2) != 0 || RAMP_DIV < 1) begin : g_bad_param
        $error("psm_pulse_gen: MIN_PERIOD must be even and >= 4, RAMP_DIV >= 1");
    end

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);
    localparam logic [DENS_W-1:0]   FULL  = '1;

    state_t              state;
    logic [PERIOD_W-1:0] cnt, per;
    logic [DENS_W-1:0]   acc;
    logic                fire;

    logic [PERIOD_W-1:0] per_even, per_nxt;
    logic [DENS_W-1:0]   dens, acc_base, acc_nxt;
    logic [DENS_W:0]     sum;
    logic                fire_nxt, at_end, start;

    assign at_end = (state == RUN) && (cnt == per - 1'b1);
    assign start  = iEN && ((state == IDLE) || at_end);

    always_comb begin
        per_even = iPERIOD & ~PERIOD_W'(1);
        per_nxt  = (per_even < MIN_P) ? MIN_P : per_even;
        // Accumulator restarts from zero on entry so the skip pattern is repeatable.
        acc_base = (state == IDLE) ? '0 : acc;
        sum      = {1'b0, acc_base} + {1'b0, dens};
        fire_nxt = sum[DENS_W];
        acc_nxt  = sum[DENS_W-1:0];
        if (dens == FULL) begin
            fire_nxt = 1'b1;
            acc_nxt  = acc_base;
        end
    end

`ifdef SOFT_START_EN
    localparam int RC_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    logic [RC_W-1:0]   rc, rc_nxt;
    logic [DENS_W-1:0] dq, d_step;

    // rc tracks the period index modulo RAMP_DIV; index 0 is the entry period.
    always_comb begin
        rc_nxt = ((state == IDLE) || (rc == RC_W'(RAMP_DIV - 1))) ? '0 : rc + 1'b1;
        if (state == IDLE)
            d_step = '0;
        else if ((rc_nxt == '0) && (dq < iDENSITY))
            d_step = dq + 1'b1;
        else
            d_step = dq;
        dens = (iDENSITY < d_step) ? iDENSITY : d_step;
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            rc <= '0;
            dq <= '0;
        end else if (start) begin
            rc <= rc_nxt;
            dq <= dens;
        end
    end
`else
    assign dens = iDENSITY;
`endif

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state <= IDLE;
            cnt   <= '0;
            per   <= MIN_P;
            acc   <= '0;
            fire  <= 1'b0;
            oPSM  <= 1'b0;
            oSYNC <= 1'b0;
            oFIRE <= 1'b0;
            oBUSY <= 1'b0;
        end else if (start) begin
            state <= RUN;
            cnt   <= '0;
            per   <= per_nxt;
            acc   <= acc_nxt;
            fire  <= fire_nxt;
            oPSM  <= fire_nxt;  // k=0 is always in the high half
            oSYNC <= 1'b1;
            oFIRE <= fire_nxt;
            oBUSY <= 1'b1;
        end else if ((state == IDLE) || at_end) begin
            state <= IDLE;
            cnt   <= '0;
            fire  <= 1'b0;
            oPSM  <= 1'b0;
            oSYNC <= 1'b0;
            oFIRE <= 1'b0;
            oBUSY <= 1'b0;
        end else begin
            cnt   <= cnt + 1'b1;
            oPSM  <= fire && ((cnt + 1'b1) < (per >> 1));
            oSYNC <= 1'b0;
            oFIRE <= fire;
            oBUSY <= 1'b1;
        end
    end

endmodule

// File: tb/tb_psm_pulse_gen.sv
// Bench for psm_pulse_gen (default build): cycle-level reference model plus
// literal window counts for the carrier, skip pattern, period clamp and stop/reset.
module tb_psm_pulse_gen;

    logic        clk = 1'b0;
    logic        n_rst, iEN;
    logic [15:0] iPERIOD;
    logic [7:0]  iDENSITY;
    logic        oPSM, oSYNC, oFIRE, oBUSY;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;
    int w_sync, w_psm, w_fsync;

    psm_pulse_gen #(.PERIOD_W(16), .DENS_W(8), .MIN_PERIOD(4), .RAMP_DIV(16)) dut (
        .clk(clk), .n_rst(n_rst), .iEN(iEN), .iPERIOD(iPERIOD), .iDENSITY(iDENSITY),
        .oPSM(oPSM), .oSYNC(oSYNC), .oFIRE(oFIRE), .oBUSY(oBUSY)
    );

    always #5 clk = ~clk;

    // Reference model: a run is a sequence of periods; each period start
    // picks an even period (>= 4) and fires when the density total carries past 256.
    bit m_run, m_fire;
    int m_k, m_p, m_acc;

    function automatic int eff_p(input int per);
        int e = per - (per % 2);
        return (e < 4) ? 4 : e;
    endfunction

    function automatic bit fires(input int base, input int d);
        return (d == 255) ? 1'b1 : ((base + d) >= 256);
    endfunction

    function automatic int acc_after(input int base, input int d);
        return (d == 255) ? base : ((base + d) % 256);
    endfunction

    always @(posedge clk) begin
        if (!n_rst) begin
            m_run <= 0; m_k <= 0; m_fire <= 0; m_acc <= 0; m_p <= 4;
        end else if (iEN && (!m_run || m_k == m_p - 1)) begin
            m_run  <= 1;
            m_k    <= 0;
            m_p    <= eff_p(int'(iPERIOD));
            m_fire <= fires(m_run ? m_acc : 0, int'(iDENSITY));
            m_acc  <= acc_after(m_run ? m_acc : 0, int'(iDENSITY));
        end else if (m_run && m_k == m_p - 1) begin
            m_run <= 0; m_k <= 0; m_fire <= 0;
        end else if (m_run) begin
            m_k <= m_k + 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: compare against the model on the falling edge, then return #1 after the rising edge.
    task automatic tick();
        @(negedge clk);
        if (chk_en) begin
            chk("model_psm",  int'(oPSM),  int'(m_run && m_fire && (m_k < m_p / 2)));
            chk("model_sync", int'(oSYNC), int'(m_run && (m_k == 0)));
            chk("model_fire", int'(oFIRE), int'(m_run && m_fire));
            chk("model_busy", int'(oBUSY), int'(m_run));
        end
        w_sync  += int'(oSYNC);
        w_psm   += int'(oPSM);
        w_fsync += int'(oSYNC && oFIRE);
        @(posedge clk);
        #1;
    endtask

    task automatic stop_idle();
        iEN = 1'b0;
        repeat (25) tick();
        chk("stop_idle_busy", int'(oBUSY), 0);
    endtask

    task automatic run(input int per, input int dens, input int n);
        iPERIOD = 16'(per); iDENSITY = 8'(dens); iEN = 1'b1;
        w_sync = 0; w_psm = 0; w_fsync = 0;
        repeat (n) tick();
    endtask

    initial begin
        n_rst = 1'b0; iEN = 1'b0; iPERIOD = 16'd20; iDENSITY = 8'd255;
        tick();
        chk_en = 1'b1;
        tick(); tick();
        chk("reset_outputs", int'({oPSM, oSYNC, oFIRE, oBUSY}), 0);
        n_rst = 1'b1;
        tick();

        // Full density: 10 high / 10 low, every period fires.
        run(20, 255, 60);
        chk("t1_sync", w_sync, 3); chk("t1_psm", w_psm, 30); chk("t1_fsync", w_fsync, 3);
        stop_idle();

        // Half density: skip, fire, skip, fire.
        run(20, 128, 80);
        chk("t2_sync", w_sync, 4); chk("t2_psm", w_psm, 20); chk("t2_fsync", w_fsync, 2);
        stop_idle();

        // Quarter density: periods 4 and 8 fire.
        run(20, 64, 160);
        chk("t3_sync", w_sync, 8); chk("t3_psm", w_psm, 20); chk("t3_fsync", w_fsync, 2);
        stop_idle();

        // Zero density: sync keeps pulsing, nothing fires.
        run(20, 0, 60);
        chk("t3b_sync", w_sync, 3); chk("t3b_psm", w_psm, 0); chk("t3b_fsync", w_fsync, 0);
        stop_idle();

        // Odd period rounds down to 20.
        run(21, 255, 60);
        chk("t4_sync", w_sync, 3); chk("t4_psm", w_psm, 30);
        stop_idle();

        // Period below minimum clamps to 4: 2 high / 2 low.
        run(2, 255, 20);
        chk("t4b_sync", w_sync, 5); chk("t4b_psm", w_psm, 10);
        stop_idle();

        // iEN drops at k=5: period still runs through k=19.
        run(20, 255, 6);
        iEN = 1'b0;
        repeat (14) tick();
        chk("t5_busy_k19", int'(oBUSY), 1);
        chk("t5_psm_k19", int'(oPSM), 0);
        tick();
        chk("t5_after_end", int'({oPSM, oSYNC, oFIRE, oBUSY}), 0);

        // Reset at k=3 clears everything next cycle.
        run(20, 255, 4);
        chk("t5_psm_k3", int'(oPSM), 1);
        n_rst = 1'b0;
        tick();
        chk("t5_reset_mid", int'({oPSM, oSYNC, oFIRE, oBUSY}), 0);
        n_rst = 1'b1; iEN = 1'b0;
        tick();

        // iEN falls exactly at the last cycle of the period.
        run(20, 255, 19);
        iEN = 1'b0;
        tick();
        chk("t6_last_busy", int'(oBUSY), 1);
        tick();
        chk("t6_idle_busy", int'(oBUSY), 0);

        // Mid-period period/density change waits for the next boundary.
        run(20, 255, 5);
        iPERIOD = 16'd8; iDENSITY = 8'd128;
        repeat (15) tick();
        chk("t7_still_fire", int'(oFIRE), 1);
        repeat (40) tick();
        stop_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
